// File: rtl/tune_sequencer.sv
// Tune sequencer: walks a synchronous note ROM and plays each {note,dur} entry
// for dur milliseconds. A silent gap follows each note. Start, stop and loop
// control are provided, along with a one-cycle beat pulse at the start of each note.
module tune_sequencer #(
    parameter int ADDR_W = 5,
    parameter int NOTE_W = 8,
    parameter int DUR_W  = 8,
    parameter int GAP_MS = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [15:0]             ticks_per_milli,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    loop_en,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_data,
    output logic [NOTE_W-1:0]       note_out,
    output logic                    note_valid,
    output logic                    beat,
    output logic                    busy,
    output logic                    done
);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, GAP} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [DUR_W-1:0]  GAP_CNT   = DUR_W'(GAP_MS);
    localparam logic [DUR_W-1:0]  ONE_MS    = DUR_W'(1);

    state_t             state;
    logic [15:0]        presc;
    logic [DUR_W-1:0]   ms_cnt;
    logic [15:0]        tpm_eff;
    logic [NOTE_W-1:0]  rom_note;
    logic [DUR_W-1:0]   rom_dur;
    logic               ms_tick;
    logic               period_end;
    logic               advance;

    // Split the ROM word and derive the ms timing strobes
    always_comb begin
        {rom_note, rom_dur} = rom_data;
        tpm_eff    = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
        ms_tick    = (presc == 16'd0);
        period_end = ms_tick && (ms_cnt == ONE_MS);
        advance    = period_end && ((state == GAP) || (state == PLAY && GAP_MS == 0));
    end

    // Sequencer FSM with registered outputs. The prescaler is a down-counter
    // reloaded from ticks_per_milli, so a new rate only applies at the next reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            presc      <= '0;
            ms_cnt     <= '0;
            rom_addr   <= '0;
            note_out   <= '0;
            note_valid <= 1'b0;
            beat       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            beat <= 1'b0;
            done <= 1'b0;
            if (stop) begin
                state      <= IDLE;
                presc      <= '0;
                ms_cnt     <= '0;
                rom_addr   <= '0;
                note_valid <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        rom_addr <= '0;
                        if (start) begin
                            state <= FETCH;
                            busy  <= 1'b1;
                        end
                    end
                    FETCH: state <= WAIT;
                    WAIT: begin
                        if (rom_dur == '0) begin
                            if (loop_en && rom_addr != '0) begin
                                rom_addr <= '0;
                                state    <= FETCH;
                            end else begin
                                rom_addr <= '0;
                                done     <= 1'b1;
                                busy     <= 1'b0;
                                state    <= IDLE;
                            end
                        end else begin
                            note_out   <= rom_note;
                            note_valid <= (rom_note != '0);
                            beat       <= 1'b1;
                            ms_cnt     <= rom_dur;
                            presc      <= tpm_eff - 16'd1;
                            state      <= PLAY;
                        end
                    end
                    PLAY, GAP: begin
                        if (ms_tick) begin
                            presc <= tpm_eff - 16'd1;
                            if (!period_end)
                                ms_cnt <= ms_cnt - ONE_MS;
                        end else begin
                            presc <= presc - 16'd1;
                        end
                        if (period_end) begin
                            note_valid <= 1'b0;
                            if (advance) begin
                                if (rom_addr == LAST_ADDR) begin
                                    rom_addr <= '0;
                                    if (loop_en) begin
                                        state <= FETCH;
                                    end else begin
                                        done  <= 1'b1;
                                        busy  <= 1'b0;
                                        state <= IDLE;
                                    end
                                end else begin
                                    rom_addr <= rom_addr + 1'b1;
                                    state    <= FETCH;
                                end
                            end else begin
                                ms_cnt <= GAP_CNT;
                                state  <= GAP;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tune_sequencer.sv
// Testbench for tune_sequencer. A reference model builds the expected per-cycle
// output timeline directly from the tune contents and the ms rate.
module tb_tune_sequencer;
    localparam int ADDR_W = 5;
    localparam int NOTE_W = 8;
    localparam int DUR_W  = 8;
    localparam int GAP_MS = 1;

    typedef struct packed {
        logic       nv;
        logic       beat;
        logic       done;
        logic       busy;
        logic [7:0] note;
        logic [4:0] addr;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] ticks_per_milli = 16'd1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop_en = 1'b0;
    logic [4:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic [7:0]  note_out;
    logic        note_valid;
    logic        beat;
    logic        busy;
    logic        done;

    logic [15:0] rom [32];
    int          checks = 0;
    int          fails = 0;
    logic [7:0]  last_note = '0;
    obs_t        exp_q[$];
    obs_t        got_q[$];

    tune_sequencer #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W), .GAP_MS(GAP_MS)) dut (
        .clk(clk), .rst_n(rst_n), .ticks_per_milli(ticks_per_milli), .start(start),
        .stop(stop), .loop_en(loop_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .note_out(note_out), .note_valid(note_valid), .beat(beat), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    function automatic obs_t mk(input logic nv, input logic bt, input logic dn,
                                input logic bs, input logic [7:0] nt, input int ad);
        obs_t o;
        o.nv = nv; o.beat = bt; o.done = dn; o.busy = bs; o.note = nt; o.addr = ad[4:0];
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(note_valid, beat, done, busy, note_out, int'(rom_addr));
    endfunction

    // Expected timeline, one entry per clock after the edge that samples start
    task automatic build_model(input int tpm, input logic lp, input int max_cycles);
        int t = (tpm == 0) ? 1 : tpm;
        int a = 0;
        int dur;
        logic [7:0] nt;
        logic [7:0] hold = last_note;
        bit fin = 0;
        exp_q.delete();
        while (!fin && exp_q.size() < max_cycles) begin
            exp_q.push_back(mk(0, 0, 0, 1, hold, a));
            exp_q.push_back(mk(0, 0, 0, 1, hold, a));
            nt  = rom[a][15:8];
            dur = int'(rom[a][7:0]);
            if (dur == 0) begin
                if (lp && a != 0) a = 0;
                else begin
                    exp_q.push_back(mk(0, 0, 1, 0, hold, 0));
                    fin = 1;
                end
            end else begin
                hold = nt;
                for (int i = 0; i < dur * t; i++) exp_q.push_back(mk(nt != 0, i == 0, 0, 1, hold, a));
                for (int i = 0; i < GAP_MS * t; i++) exp_q.push_back(mk(0, 0, 0, 1, hold, a));
                if (a == 31) begin
                    if (lp) a = 0;
                    else begin
                        exp_q.push_back(mk(0, 0, 1, 0, hold, 0));
                        fin = 1;
                    end
                end else a++;
            end
        end
        while (exp_q.size() > max_cycles) void'(exp_q.pop_back());
        last_note = hold;
    endtask

    // Pulse start from IDLE and record n samples, the first just after the start edge
    task automatic capture(input int n);
        got_q.delete();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        got_q.push_back(sample());
        for (int i = 1; i < n; i++) begin
            @(posedge clk);
            #1 got_q.push_back(sample());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sample() !== mk(0, 0, 0, 0, 8'h00, 0)) begin
            fails++;
            $display("FAIL reset: got %h expected %h", sample(), mk(0, 0, 0, 0, 8'h00, 0));
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        ticks_per_milli = 16'd4;
        rom[0] = {8'h10, 8'd2};
        rom[1] = 16'h0000;
        build_model(4, 0, 1000);
        capture(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL basic cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_rest();
        ticks_per_milli = 16'd4;
        rom[0] = {8'h00, 8'd3};
        rom[1] = {8'h22, 8'd1};
        rom[2] = 16'h0000;
        build_model(4, 0, 1000);
        capture(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL rest cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int n;
        int tpm;
        logic [7:0] nt;
        logic [7:0] du;
        for (int r = 0; r < 5; r++) begin
            tpm = $urandom_range(0, 4);
            ticks_per_milli = tpm[15:0];
            n = $urandom_range(1, 6);
            for (int j = 0; j < n; j++) begin
                nt = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                du = 8'($urandom_range(1, 4));
                rom[j] = {nt, du};
            end
            rom[n] = 16'h0000;
            build_model(tpm, 0, 1000);
            capture(exp_q.size());
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    fails++;
                    $display("FAIL random run %0d tpm %0d cycle %0d: got %h expected %h",
                             r, tpm, i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_tpm0_empty();
        ticks_per_milli = 16'd0;
        rom[0] = {8'h33, 8'd3};
        rom[1] = 16'h0000;
        build_model(0, 0, 1000);
        capture(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL tpm0 cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        rom[0] = 16'h0000;
        build_model(0, 0, 1000);
        capture(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL empty cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_loop();
        bit seen = 0;
        ticks_per_milli = 16'd2;
        rom[0] = {8'h05, 8'd1};
        rom[1] = 16'h0000;
        loop_en = 1'b1;
        build_model(2, 1, 60);
        capture(60);
        for (int i = 0; i < 60; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL loop cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        loop_en = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk);
            #1 if (done) seen = 1;
        end
        checks++;
        if (!seen || busy !== 1'b0) begin
            fails++;
            $display("FAIL loop_exit: done seen %0d busy %b, required done seen 1 busy 0", seen, busy);
        end
    endtask

    task automatic test_stop();
        bit playing = 0;
        ticks_per_milli = 16'd3;
        rom[0] = {8'h44, 8'd5};
        rom[1] = 16'h0000;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 10 && !playing; i++) begin
            @(posedge clk);
            #1 if (note_valid) playing = 1;
        end
        checks++;
        if (!playing) begin
            fails++;
            $display("FAIL stop_setup: note_valid never rose, required 1");
        end
        repeat (3) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (sample() !== mk(0, 0, 0, 0, 8'h44, 0)) begin
            fails++;
            $display("FAIL stop_midplay: got %h expected %h", sample(), mk(0, 0, 0, 0, 8'h44, 0));
        end
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || beat !== 1'b0) begin
                fails++;
                $display("FAIL stop_start_idle cycle %0d: busy %b done %b beat %b, required 0 0 0",
                         i, busy, done, beat);
            end
        end
        start = 1'b0;
        stop = 1'b0;
        last_note = 8'h44;
        @(posedge clk);
    endtask

    task automatic test_full();
        bit wrapped = 0;
        ticks_per_milli = 16'd1;
        for (int j = 0; j < 32; j++) rom[j] = {8'($urandom_range(1, 255)), 8'd1};
        build_model(1, 0, 1000);
        capture(exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL full cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
        loop_en = 1'b1;
        build_model(1, 1, 150);
        capture(150);
        for (int i = 0; i < 150; i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL full_loop cycle %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
            if (i > 0 && got_q[i-1].addr == 5'd31 && got_q[i].addr == 5'd0 && got_q[i].busy)
                wrapped = 1;
        end
        checks++;
        if (!wrapped) begin
            fails++;
            $display("FAIL full_wrap: rom_addr 31->0 while busy seen %0d, required 1", wrapped);
        end
        loop_en = 1'b0;
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
    endtask

    task automatic test_async_reset();
        bit playing = 0;
        ticks_per_milli = 16'd4;
        rom[0] = {8'h66, 8'd4};
        rom[1] = 16'h0000;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 10 && !playing; i++) begin
            @(posedge clk);
            #1 if (note_valid) playing = 1;
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (!playing || sample() !== mk(0, 0, 0, 0, 8'h00, 0)) begin
            fails++;
            $display("FAIL async_reset: playing %0d got %h expected %h", playing, sample(),
                     mk(0, 0, 0, 0, 8'h00, 0));
        end
        @(negedge clk) rst_n = 1'b1;
        last_note = 8'h00;
        @(posedge clk);
    endtask

    initial begin
        for (int j = 0; j < 32; j++) rom[j] = 16'h0000;
        test_reset();
        test_basic();
        test_rest();
        test_random();
        test_tpm0_empty();
        test_loop();
        test_stop();
        test_full();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
